// File: rtl/terminal_arbiter.sv
// Two-terminal (matrix / LEDs) arbiter for two authenticated stations.
// Each terminal runs its own round-robin FSM with optional hold-time preemption.
module terminal_arbiter #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       REQ0,
    input  logic       REQ1,
    input  logic       AUT0,
    input  logic       AUT1,
    input  logic       TERM0,
    input  logic       TERM1,
    input  logic [2:0] CF0,
    input  logic [2:0] CF1,
    output logic       GNT0,
    output logic       GNT1,
    output logic       SEL_MATRIZ,
    output logic       SEL_LEDS,
    output logic       BUSY_MATRIZ,
    output logic       BUSY_LEDS,
    output logic [2:0] FMATRIZ,
    output logic [2:0] FLEDS
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_e;

    localparam bit         HOLD_EN  = (MAX_HOLD != 0);
    localparam logic [7:0] HOLD_LIM = HOLD_EN ? 8'(MAX_HOLD - 1) : 8'd0;

    // reff[t][i]: station i effectively requests terminal t (0 = matrix, 1 = LEDs)
    logic [1:0][1:0] reff;
    assign reff[0] = {REQ1 & AUT1 & ~TERM1, REQ0 & AUT0 & ~TERM0};
    assign reff[1] = {REQ1 & AUT1 &  TERM1, REQ0 & AUT0 &  TERM0};

    logic [1:0]      busy_d, sel_d, own0_d, own1_d;
    logic [1:0][2:0] f_d;

    for (genvar t = 0; t < 2; t++) begin : g_term
        state_e     state_q, state_d;
        logic       last_q, last_d;
        logic [7:0] hcnt_q, hcnt_d;
        logic [1:0] r;
        logic       own;
        state_e     other;

        assign r     = reff[t];
        assign own   = (state_q == OWN1);
        assign other = own ? OWN0 : OWN1;

        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                state_q <= IDLE;
                last_q  <= 1'b1;
                hcnt_q  <= '0;
            end else begin
                state_q <= state_d;
                last_q  <= last_d;
                hcnt_q  <= hcnt_d;
            end
        end

        always_comb begin
            state_d = state_q;
            last_d  = last_q;
            hcnt_d  = hcnt_q;
            unique case (state_q)
                IDLE: begin
                    if (r[0] && r[1])  state_d = last_q ? OWN0 : OWN1;
                    else if (r[0])     state_d = OWN0;
                    else if (r[1])     state_d = OWN1;
                end
                OWN0, OWN1: begin
                    if (!r[own])
                        state_d = r[~own] ? other : IDLE;
                    else if (r[~own] && HOLD_EN && (hcnt_q >= HOLD_LIM))
                        state_d = other;
                    else if (r[~own] && (hcnt_q != 8'hFF))
                        hcnt_d = hcnt_q + 8'd1;
                end
                default: state_d = IDLE;
            endcase
            // Any entry into an ownership state restarts the hold window.
            if ((state_d != IDLE) && (state_d != state_q)) begin
                last_d = (state_d == OWN1);
                hcnt_d = '0;
            end
        end

        assign busy_d[t] = (state_d != IDLE);
        assign sel_d[t]  = (state_d == OWN1);
        assign own0_d[t] = (state_d == OWN0);
        assign own1_d[t] = (state_d == OWN1);
        assign f_d[t]    = (state_d == OWN0) ? CF0 :
                           (state_d == OWN1) ? CF1 : 3'b000;
    end

    logic [1:0]      busy_q, sel_q, gnt_q;
    logic [1:0][2:0] f_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            busy_q <= '0;
            sel_q  <= '0;
            gnt_q  <= '0;
            f_q    <= '0;
        end else begin
            busy_q <= busy_d;
            sel_q  <= sel_d;
            gnt_q  <= {|own1_d, |own0_d};
            f_q    <= f_d;
        end
    end

    assign GNT0        = gnt_q[0];
    assign GNT1        = gnt_q[1];
    assign BUSY_MATRIZ = busy_q[0];
    assign BUSY_LEDS   = busy_q[1];
    assign SEL_MATRIZ  = sel_q[0];
    assign SEL_LEDS    = sel_q[1];
    assign FMATRIZ     = f_q[0];
    assign FLEDS       = f_q[1];

endmodule

// File: tb/tb_terminal_arbiter.sv
// Scoreboard bench for terminal_arbiter (MAX_HOLD = 4): stimulus queues the
// expected output vector, a monitor pops and compares after each edge or reset event.
module tb_terminal_arbiter;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       REQ0, REQ1, AUT0, AUT1, TERM0, TERM1;
    logic [2:0] CF0, CF1;
    logic       GNT0, GNT1, SEL_MATRIZ, SEL_LEDS, BUSY_MATRIZ, BUSY_LEDS;
    logic [2:0] FMATRIZ, FLEDS;

    terminal_arbiter #(.MAX_HOLD(4)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .REQ0(REQ0), .REQ1(REQ1), .AUT0(AUT0), .AUT1(AUT1),
        .TERM0(TERM0), .TERM1(TERM1), .CF0(CF0), .CF1(CF1),
        .GNT0(GNT0), .GNT1(GNT1),
        .SEL_MATRIZ(SEL_MATRIZ), .SEL_LEDS(SEL_LEDS),
        .BUSY_MATRIZ(BUSY_MATRIZ), .BUSY_LEDS(BUSY_LEDS),
        .FMATRIZ(FMATRIZ), .FLEDS(FLEDS)
    );

    always #5 CLK = ~CLK;

    // {GNT0, GNT1, BUSY_M, SEL_M, FMATRIZ, BUSY_L, SEL_L, FLEDS}
    logic [11:0] out_vec;
    assign out_vec = {GNT0, GNT1, BUSY_MATRIZ, SEL_MATRIZ, FMATRIZ, BUSY_LEDS, SEL_LEDS, FLEDS};

    typedef struct {
        string       name;
        logic [11:0] exp;
    } sb_t;

    sb_t  sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    event chk_async;

    function automatic logic [11:0] mk(input logic g0, input logic g1,
                                       input logic bm, input logic sm, input logic [2:0] fm,
                                       input logic bl, input logic sl, input logic [2:0] fl);
        return {g0, g1, bm, sm, fm, bl, sl, fl};
    endfunction

    // Monitor
    initial begin
        sb_t e;
        forever begin
            @(posedge CLK or chk_async);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_tests++;
                if (out_vec !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s: got %03h expected %03h", e.name, out_vec, e.exp);
                end
            end
        end
    end

    task automatic tick(input string name, input logic [11:0] exp);
        sb.push_back('{name, exp});
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // Async reset pulse between edges; outputs must clear without a clock edge.
    task automatic rst_pulse(input string name);
        #1 RST_N = 1'b0;
        sb.push_back('{name, 12'h000});
        ->chk_async;
        #2 RST_N = 1'b1;
    endtask

    task automatic set0(input logic rq, input logic au, input logic tm, input logic [2:0] cf);
        REQ0 = rq; AUT0 = au; TERM0 = tm; CF0 = cf;
    endtask

    task automatic set1(input logic rq, input logic au, input logic tm, input logic [2:0] cf);
        REQ1 = rq; AUT1 = au; TERM1 = tm; CF1 = cf;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        RST_N = 1'b0;
        set0(0, 0, 0, 3'b000);
        set1(0, 0, 0, 3'b000);
        #2;
        sb.push_back('{"reset_state", 12'h000});
        ->chk_async;
        @(negedge CLK);
        RST_N = 1'b1;

        // Single request on matrix
        set0(1, 1, 0, 3'b101);
        tick("single_grant", mk(1, 0, 1, 0, 3'b101, 0, 0, 3'b000));
        CF0 = 3'b011;
        tick("cf_resample", mk(1, 0, 1, 0, 3'b011, 0, 0, 3'b000));
        REQ0 = 1'b0;
        tick("release", 12'h000);

        // Tie after reset, then handover without gap
        rst_pulse("reset_pulse_a");
        set0(1, 1, 0, 3'b001);
        set1(1, 1, 0, 3'b110);
        tick("tie_own0", mk(1, 0, 1, 0, 3'b001, 0, 0, 3'b000));
        REQ0 = 1'b0;
        tick("handover_own1", mk(0, 1, 1, 1, 3'b110, 0, 0, 3'b000));
        REQ1 = 1'b0;
        tick("idle_again", 12'h000);

        // Preemption with MAX_HOLD = 4
        REQ0 = 1'b1;
        tick("c_own0", mk(1, 0, 1, 0, 3'b001, 0, 0, 3'b000));
        REQ1 = 1'b1;
        for (int i = 0; i < 3; i++)
            tick("wait_own0", mk(1, 0, 1, 0, 3'b001, 0, 0, 3'b000));
        tick("preempt_to1", mk(0, 1, 1, 1, 3'b110, 0, 0, 3'b000));
        for (int i = 0; i < 3; i++)
            tick("wait_own1", mk(0, 1, 1, 1, 3'b110, 0, 0, 3'b000));
        tick("preempt_to0", mk(1, 0, 1, 0, 3'b001, 0, 0, 3'b000));
        REQ0 = 1'b0; REQ1 = 1'b0;
        tick("c_idle", 12'h000);

        // Different terminals granted together
        set0(1, 1, 0, 3'b010);
        set1(1, 1, 1, 3'b111);
        tick("both_terms", mk(1, 1, 1, 0, 3'b010, 1, 1, 3'b111));
        TERM1 = 1'b0;
        tick("term_switch", mk(1, 0, 1, 0, 3'b010, 0, 0, 3'b000));
        REQ0 = 1'b0;
        tick("switch_gets_m", mk(0, 1, 1, 1, 3'b111, 0, 0, 3'b000));
        REQ1 = 1'b0;
        tick("e_idle", 12'h000);

        // Authentication gating
        set1(1, 0, 1, 3'b100);
        for (int i = 0; i < 3; i++)
            tick("aut_low", 12'h000);
        AUT1 = 1'b1;
        tick("aut_rise", mk(0, 1, 0, 0, 3'b000, 1, 1, 3'b100));
        AUT1 = 1'b0;
        tick("aut_fall", 12'h000);

        // Reset mid-ownership, then tie resolves to station 0
        set0(1, 1, 0, 3'b011);
        set1(1, 1, 1, 3'b101);
        tick("g_both", mk(1, 1, 1, 0, 3'b011, 1, 1, 3'b101));
        TERM1 = 1'b0;
        rst_pulse("reset_mid_own");
        tick("tie_after_rst", mk(1, 0, 1, 0, 3'b011, 0, 0, 3'b000));
        REQ0 = 1'b0;
        tick("g_handover", mk(0, 1, 1, 1, 3'b101, 0, 0, 3'b000));
        REQ1 = 1'b0;
        tick("g_idle", 12'h000);

        repeat (3) @(negedge CLK);
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/terminal_arbiter.md
TERMINAL_ARBITER -- requirements
Module: terminal_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 8: cycles an owner keeps a terminal while the other station waits; 0 disables preemption; legal range 0-255.
REQ-002 CLK  input  1  rising-edge clock, only clock of the block.
REQ-003 RST_N  input  1  asynchronous, active-low reset.
REQ-004 REQ0, REQ1  input  1 each  station 0/1 requests a terminal.
REQ-005 AUT0, AUT1  input  1 each  station 0/1 authenticated; a request with AUT low is ignored.
REQ-006 TERM0, TERM1  input  1 each  target terminal: 0 = matrix, 1 = LEDs.
REQ-007 CF0, CF1  input  3 each  encoded function of station 0/1.
REQ-008 GNT0, GNT1  output  1 each  station 0/1 currently owns its target terminal.
REQ-009 SEL_MATRIZ, SEL_LEDS  output  1 each  owning station of matrix/LEDs (0/1); meaningful only while the matching BUSY is high.
REQ-010 BUSY_MATRIZ, BUSY_LEDS  output  1 each  terminal owned.
REQ-011 FMATRIZ, FLEDS  output  3 each  function code forwarded to the matrix/LED decoder.

Function
REQ-012 Effective request: Ri(t) = REQi AND AUTi AND (TERMi == t), for station i, terminal t.
REQ-013 Each terminal SHALL have an independent FSM with states IDLE, OWN0, OWN1, plus a 1-bit round-robin pointer LAST_t and an 8-bit hold counter HCNT_t.
REQ-014 IDLE: neither Ri(t) -> IDLE; only Ri(t) -> OWNi; both -> OWN of the station not equal to LAST_t.
REQ-015 OWNi: Ri(t) low -> OWNj if Rj(t) high, else IDLE; no idle cycle between owners.
REQ-016 OWNi with Ri(t) high, Rj(t) high, MAX_HOLD != 0 and HCNT_t >= MAX_HOLD-1 -> OWNj (preemption); else stay OWNi.
REQ-017 On every entry to OWNi, LAST_t SHALL become i and HCNT_t SHALL clear to 0.
REQ-018 In OWNi, HCNT_t increments each cycle that Rj(t) is high, saturating at 255; it holds while Rj(t) is low.
REQ-019 All outputs SHALL be registered and updated on the same edge as the state; grant latency is exactly one edge from request sampled.
REQ-020 BUSY_t = 1 in OWN0/OWN1; SEL_t = owner index; in IDLE SEL_t = 0.
REQ-021 F_t SHALL carry CF of the owning station, re-sampled every edge while owned; 3'b000 in IDLE.
REQ-022 GNTi = 1 iff station i owns either terminal; a station never owns both since TERMi is single-bit.
REQ-023 Owner changing TERMi SHALL release the old terminal and request the new one on the same edge; the new grant follows REQ-014/015 for that terminal.
REQ-024 AUTi falling while owning SHALL release on the next edge, identical to REQ dropping.
REQ-025 Stations targeting different terminals SHALL both be granted on the same edge.
REQ-026 A preempted station with REQ still high SHALL re-acquire the terminal when the new owner releases or is itself preempted; no starvation beyond MAX_HOLD cycles.

Reset
REQ-027 RST_N low SHALL immediately force both FSMs to IDLE, LAST_t = 1 (station 0 wins first tie), HCNT_t = 0, all outputs 0, independent of CLK.
REQ-028 Reset asserted mid-ownership SHALL drop grants without completing the hold; first grant after release occurs on the first edge with RST_N high.

Verification
REQ-029 Reset, then REQ0=AUT0=1, TERM0=0, CF0=3'b101 -> after one edge GNT0=1, BUSY_MATRIZ=1, SEL_MATRIZ=0, FMATRIZ=3'b101; FLEDS=0.
REQ-030 Both stations request matrix on the same edge after reset -> OWN0; REQ0 drops -> next edge SEL_MATRIZ=1, GNT1=1, GNT0=0, no BUSY gap.
REQ-031 MAX_HOLD=4, station 0 owns matrix, station 1 requests matrix continuously -> after 4 waiting edges ownership passes to station 1; 4 further edges return it to station 0.
REQ-032 Station 0 TERM0=0, station 1 TERM1=1, both authenticated -> after one edge GNT0=GNT1=1, BUSY_MATRIZ=BUSY_LEDS=1, FMATRIZ=CF0, FLEDS=CF1.
REQ-033 REQ1=1 with AUT1=0 -> GNT1 stays 0 indefinitely; AUT1 rising -> grant one edge later.
REQ-034 RST_N pulsed low between edges while both terminals owned -> all outputs 0 immediately; after release, held requests regranted with station 0 winning ties.
